// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one uart_tx among NUM_REQ requesters
// Every output is a register loaded from the next-value logic in the combinational process.

module uart_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 2048
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            grant,
    output logic [NUM_REQ-1:0]            ack,
    output logic                          newd,
    output logic [DATA_WIDTH-1:0]         din,
    input  logic                          done_tx,
    output logic                          busy,
    output logic                          timeout_err,
    input  logic                          clr_err
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SW = IW + 1;
    localparam logic [NUM_REQ-1:0] ONE     = 1;
    localparam logic [IW-1:0]      LAST_RST = IW'(NUM_REQ - 1);
    localparam logic [15:0]        CNT_MAX  = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

    state_t                state, state_next;
    logic [IW-1:0]         last, last_next;
    logic [IW-1:0]         owner, owner_next;
    logic [15:0]           cnt, cnt_next;
    logic [NUM_REQ-1:0]    grant_next, ack_next;
    logic                  newd_next, busy_next, err_next;
    logic [DATA_WIDTH-1:0] din_next;

    logic                  pick_valid;
    logic [IW-1:0]         pick_idx;
    logic [DATA_WIDTH-1:0] pick_data;
    logic [SW-1:0]         pos;

    // Walk offsets from farthest to nearest so the requester closest after 'last' is kept.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        pick_data  = '0;
        pos        = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            pos = {1'b0, last} + SW'(k);
            if (pos >= SW'(NUM_REQ))
                pos = pos - SW'(NUM_REQ);
            for (int j = 0; j < NUM_REQ; j++) begin
                if (req[j] && pos == SW'(j)) begin
                    pick_valid = 1'b1;
                    pick_idx   = IW'(j);
                    pick_data  = req_data[j*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        last_next  = last;
        owner_next = owner;
        cnt_next   = cnt;
        grant_next = grant;
        ack_next   = '0;
        newd_next  = 1'b0;
        din_next   = din;
        err_next   = clr_err ? 1'b0 : timeout_err;
        case (state)
            IDLE: begin
                grant_next = '0;
                if (pick_valid) begin
                    state_next = SEND;
                    grant_next = ONE << pick_idx;
                    din_next   = pick_data;
                    newd_next  = 1'b1;
                    owner_next = pick_idx;
                    cnt_next   = '0;
                end
            end
            SEND: begin
                state_next = WAIT;
                cnt_next   = '0;
            end
            WAIT: begin
                // done_tx takes priority over an expiring counter in the same cycle.
                if (done_tx) begin
                    state_next = DONE;
                    grant_next = '0;
                    ack_next   = ONE << owner;
                    last_next  = owner;
                end else if (cnt == CNT_MAX) begin
                    state_next = IDLE;
                    grant_next = '0;
                    err_next   = 1'b1;
                    last_next  = owner;
                end else begin
                    cnt_next = cnt + 16'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            last        <= LAST_RST;
            owner       <= '0;
            cnt         <= '0;
            grant       <= '0;
            ack         <= '0;
            newd        <= 1'b0;
            din         <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_next;
            last        <= last_next;
            owner       <= owner_next;
            cnt         <= cnt_next;
            grant       <= grant_next;
            ack         <= ack_next;
            newd        <= newd_next;
            din         <= din_next;
            busy        <= busy_next;
            timeout_err <= err_next;
        end
    end

endmodule
